pixel_write_packer: RTL and testbench

//  Back end of the pixel pipe. Takes blended RGB888 pixels from the blend stage and converts them to VRAM 15bpp+mask.

---
 rtl/pixel_write_packer.sv | 185 ++++++++++++++++++
 tb/tb_pixel_write_packer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_packer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_write_packer
// Purpose  : RGB888 -> 15bpp+mask conversion, packed into masked VRAM segment
//            write bursts. Define PIXWB_DITHER_EN to build the 4x4 dither path.
// Revision : 1.0  initial release
// ============================================================================
module pixel_write_packer #(
  parameter int SEG_LOG2 = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_pix_valid,
  output logic                          o_pix_ready,
  input  logic [9:0]                    i_pix_x,
  input  logic [8:0]                    i_pix_y,
  input  logic [7:0]                    i_r,
  input  logic [7:0]                    i_g,
  input  logic [7:0]                    i_b,
  input  logic                          i_stp,
  input  logic                          i_force_mask,
  input  logic                          i_dither,
  input  logic                          i_flush,
  output logic                          o_wr_valid,
  input  logic                          i_wr_ready,
  output logic [18-SEG_LOG2:0]          o_wr_addr,
  output logic [16*(1<<SEG_LOG2)-1:0]   o_wr_data,
  output logic [(1<<SEG_LOG2)-1:0]      o_wr_mask,
  output logic                          o_busy
);

  localparam int SEG = 1 << SEG_LOG2;
  localparam int AW  = 19 - SEG_LOG2;
  localparam int DW  = 16 * SEG;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        buf_q, buf_d;
  logic [SEG-1:0]       mask_q, mask_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 hold_full_q, hold_full_d;
  logic [15:0]          hold_pix_q, hold_pix_d;
  logic [SEG_LOG2-1:0]  hold_slot_q, hold_slot_d;
  logic [AW-1:0]        hold_addr_q, hold_addr_d;

  logic [4:0]           r5, g5, b5;
  logic [15:0]          pix16;
  logic [AW-1:0]        pix_addr;
  logic [SEG_LOG2-1:0]  pix_slot;
  logic [SEG-1:0]       pix_bit;
  logic                 accept;
  logic                 same_seg;

`ifdef PIXWB_DITHER_EN
  // Entry {y[1:0],x[1:0]} holds the signed 4-bit offset at bits [4*idx+3:4*idx].
  localparam logic [63:0] DITHER_TBL = 64'hE2F3_0C1D_F3E2_1D0C;

  logic [3:0] dith_off;
  assign dith_off = DITHER_TBL[{i_pix_y[1:0], i_pix_x[1:0], 2'b00} +: 4];

  function automatic logic [4:0] dither5(input logic [7:0] c, input logic [3:0] d);
    logic signed [9:0] s;
    s = $signed({2'b00, c}) + $signed({{6{d[3]}}, d});
    if (s < 10'sd0)   return 5'd0;
    if (s > 10'sd255) return 5'd31;
    return s[7:3];
  endfunction

  assign r5 = i_dither ? dither5(i_r, dith_off) : i_r[7:3];
  assign g5 = i_dither ? dither5(i_g, dith_off) : i_g[7:3];
  assign b5 = i_dither ? dither5(i_b, dith_off) : i_b[7:3];
`else
  logic unused_nodither;
  assign unused_nodither = ^{i_dither, i_r[2:0], i_g[2:0], i_b[2:0]};

  assign r5 = i_r[7:3];
  assign g5 = i_g[7:3];
  assign b5 = i_b[7:3];
`endif

  assign pix16    = {i_stp | i_force_mask, b5, g5, r5};
  assign pix_addr = {i_pix_y, i_pix_x[9:SEG_LOG2]};
  assign pix_slot = i_pix_x[SEG_LOG2-1:0];
  assign pix_bit  = SEG'(1) << pix_slot;
  assign accept   = i_pix_valid & o_pix_ready;
  assign same_seg = (pix_addr == addr_q);

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    mask_d      = mask_q;
    addr_d      = addr_q;
    hold_full_d = hold_full_q;
    hold_pix_d  = hold_pix_q;
    hold_slot_d = hold_slot_q;
    hold_addr_d = hold_addr_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          buf_d[{pix_slot, 4'b0000} +: 16] = pix16;
          mask_d  = mask_q | pix_bit;
          addr_d  = pix_addr;
          state_d = FILL;
        end
      end

      FILL: begin
        if (accept && same_seg) begin
          buf_d[{pix_slot, 4'b0000} +: 16] = pix16;
          mask_d = mask_q | pix_bit;
        end else if (accept) begin
          hold_full_d = 1'b1;
          hold_pix_d  = pix16;
          hold_slot_d = pix_slot;
          hold_addr_d = pix_addr;
        end
        if (i_flush || hold_full_d || (&mask_d)) begin
          state_d = FLUSH;
        end
      end

      FLUSH: begin
        // The buffer is frozen for the burst; anything arriving now waits in hold.
        if (accept) begin
          hold_full_d = 1'b1;
          hold_pix_d  = pix16;
          hold_slot_d = pix_slot;
          hold_addr_d = pix_addr;
        end
        if (i_wr_ready) begin
          buf_d  = '0;
          mask_d = '0;
          if (hold_full_d) begin
            buf_d[{hold_slot_d, 4'b0000} +: 16] = hold_pix_d;
            mask_d      = SEG'(1) << hold_slot_d;
            addr_d      = hold_addr_d;
            hold_full_d = 1'b0;
            state_d     = FILL;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      mask_q      <= '0;
      addr_q      <= '0;
      hold_full_q <= 1'b0;
      hold_pix_q  <= '0;
      hold_slot_q <= '0;
      hold_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      mask_q      <= mask_d;
      addr_q      <= addr_d;
      hold_full_q <= hold_full_d;
      hold_pix_q  <= hold_pix_d;
      hold_slot_q <= hold_slot_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  assign o_pix_ready = ~hold_full_q;
  assign o_wr_valid  = (state_q == FLUSH);
  assign o_wr_addr   = addr_q;
  assign o_wr_data   = buf_q;
  assign o_wr_mask   = mask_q;
  assign o_busy      = (state_q != IDLE) | hold_full_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_write_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_write_packer
// Purpose  : directed and randomized bench for pixel_write_packer with a
//            segment-level reference model and burst scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_pixel_write_packer;

  localparam int SEG_LOG2 = 4;

`ifdef PIXWB_DITHER_EN
  localparam bit DITH_BUILT = 1'b1;
`else
  localparam bit DITH_BUILT = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         pv, ready;
  logic [9:0]   px;
  logic [8:0]   py;
  logic [7:0]   pr, pg, pb;
  logic         stp, fm, dith, flush;
  logic         wr_valid, wrr, busy;
  logic [14:0]  wr_addr;
  logic [255:0] wr_data;
  logic [15:0]  wr_mask;

  pixel_write_packer #(.SEG_LOG2(SEG_LOG2)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_pix_valid  (pv),
    .o_pix_ready  (ready),
    .i_pix_x      (px),
    .i_pix_y      (py),
    .i_r          (pr),
    .i_g          (pg),
    .i_b          (pb),
    .i_stp        (stp),
    .i_force_mask (fm),
    .i_dither     (dith),
    .i_flush      (flush),
    .o_wr_valid   (wr_valid),
    .i_wr_ready   (wrr),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_wr_mask    (wr_mask),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [14:0]  addr;
    logic [15:0]  mask;
    logic [255:0] data;
  } burst_t;

  burst_t       exp_q[$];
  bit           m_open;
  logic [14:0]  m_addr;
  logic [15:0]  m_mask;
  logic [255:0] m_data;
  int           n_checks, n_pass, burst_cnt;
  logic [14:0]  lb_addr;
  logic [15:0]  lb_mask;
  logic [255:0] lb_data;
  int           dtab [4][4] = '{'{-4, 0, -3, 1}, '{2, -2, 3, -1},
                                '{-3, 1, -4, 0}, '{3, -1, 2, -2}};

  function automatic logic [4:0] conv5(input int c, input int d, input bit en);
    int v = c;
    if (en) begin
      v = c + d;
      if (v < 0)   v = 0;
      if (v > 255) v = 255;
    end
    return 5'(v / 8);
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic emit();
    exp_q.push_back('{addr: m_addr, mask: m_mask, data: m_data});
    m_open = 1'b0;
  endtask

  // Segment-level view: pixels merge into the open segment until it fills,
  // a pixel for another segment arrives, or a flush closes it.
  task automatic model_accept();
    logic [14:0] a;
    logic [15:0] p;
    int          slot, d;
    bit          en;
    en   = DITH_BUILT && dith;
    d    = dtab[py[1:0]][px[1:0]];
    p    = {stp | fm, conv5(int'(pb), d, en), conv5(int'(pg), d, en), conv5(int'(pr), d, en)};
    a    = 15'(int'(py) * 64 + int'(px) / 16);
    slot = int'(px) % 16;
    if (m_open && a != m_addr) emit();
    if (!m_open) begin
      m_open = 1'b1;
      m_addr = a;
      m_mask = '0;
      m_data = '0;
    end
    m_data[slot*16 +: 16] = p;
    m_mask[slot]          = 1'b1;
    if (m_mask == 16'hFFFF) emit();
  endtask

  task automatic check_burst();
    burst_t e;
    burst_cnt++;
    lb_addr = wr_addr;
    lb_mask = wr_mask;
    lb_data = wr_data;
    check("burst_expected", 256'(exp_q.size() != 0), 256'(1));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("burst_addr", 256'(wr_addr), 256'(e.addr));
      check("burst_mask", 256'(wr_mask), 256'(e.mask));
      check("burst_data", wr_data, e.data);
    end
  endtask

  // Inputs are applied just after a falling edge; evaluate handshakes, then advance one cycle.
  task automatic tick();
    if (!rst) begin
      if (wr_valid && wrr) check_burst();
      if (pv && ready) model_accept();
      if (flush && m_open) emit();
    end
    @(negedge clk);
  endtask

  task automatic send(input int x, input int y, input int r, input int g, input int b,
                      input bit s, input bit f, input bit d, output int tries);
    bit ok;
    pv = 1'b1; px = 10'(x); py = 9'(y);
    pr = 8'(r); pg = 8'(g); pb = 8'(b);
    stp = s; fm = f; dith = d;
    tries = 0;
    ok    = 1'b0;
    while (!ok && tries < 64) begin
      ok = ready;
      tick();
      tries++;
    end
    pv = 1'b0;
    if (!ok) check("send_timeout", 256'(ok), 256'(1));
  endtask

  task automatic flush_all();
    bit done = 1'b0;
    pv = 1'b0; flush = 1'b1; wrr = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      done = !busy;
    end
    flush = 1'b0;
    if (!done) check("flush_timeout", 256'(busy), 256'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  t;
    bit  stall;
    n_checks = 0; n_pass = 0; burst_cnt = 0; m_open = 1'b0;
    rst = 1'b1; pv = 1'b0; px = '0; py = '0; pr = '0; pg = '0; pb = '0;
    stp = 1'b0; fm = 1'b0; dith = 1'b0; flush = 1'b0; wrr = 1'b0;
    @(negedge clk);
    tick(); tick(); tick();
    rst = 1'b0;

    check("rst_wr_valid", 256'(wr_valid), 256'(0));
    check("rst_wr_mask",  256'(wr_mask),  256'(0));
    check("rst_wr_data",  wr_data,        256'(0));
    check("rst_wr_addr",  256'(wr_addr),  256'(0));
    check("rst_busy",     256'(busy),     256'(0));
    check("rst_ready",    256'(ready),    256'(1));

    send(2, 1, 7, 0, 0, 0, 0, 1, t); flush_all();
    check("dither_r7_on", 256'(lb_data[32 +: 5]), 256'(DITH_BUILT ? 5'd1 : 5'd0));
    send(2, 1, 7, 0, 0, 0, 0, 0, t); flush_all();
    check("dither_r7_off", 256'(lb_data[32 +: 5]), 256'(0));
    send(1, 1, 255, 0, 0, 0, 0, 1, t); flush_all();
    check("dither_clamp_hi", 256'(lb_data[16 +: 5]), 256'(31));
    send(0, 0, 2, 0, 0, 0, 0, 1, t); flush_all();
    check("dither_clamp_lo", 256'(lb_data[0 +: 5]), 256'(0));

    wrr = 1'b1; stall = 1'b0; t = burst_cnt;
    for (int i = 0; i < 16; i++) begin
      int tr;
      send(32 + i, 5, 8 * i, 255 - i, i, i % 2, 0, 0, tr);
      stall |= (tr > 1);
    end
    for (int i = 0; i < 20 && burst_cnt == t; i++) tick();
    check("full_burst_count", 256'(burst_cnt - t), 256'(1));
    check("full_no_stall", 256'(stall), 256'(0));
    check("full_addr", 256'(lb_addr), 256'(15'(5 * 64 + 2)));
    check("full_mask", 256'(lb_mask), 256'(16'hFFFF));

    wrr = 1'b0;
    send(0, 7, 100, 50, 25, 0, 0, 0, t);
    send(16, 7, 200, 60, 30, 1, 0, 0, t);
    check("segchg_ready_low", 256'(ready), 256'(0));
    check("segchg_valid", 256'(wr_valid), 256'(1));
    check("segchg_mask", 256'(wr_mask), 256'(16'h0001));
    tick();
    check("segchg_ready_low2", 256'(ready), 256'(0));
    tick();
    check("segchg_ready_low3", 256'(ready), 256'(0));
    wrr = 1'b1;
    tick();
    check("segchg_fill_valid", 256'(wr_valid), 256'(0));
    check("segchg_fill_mask", 256'(wr_mask), 256'(16'h0001));
    check("segchg_fill_addr", 256'(wr_addr), 256'(15'(7 * 64 + 1)));
    check("segchg_fill_ready", 256'(ready), 256'(1));
    check("segchg_fill_busy", 256'(busy), 256'(1));
    flush_all();

    send(3, 9, 40, 80, 120, 0, 0, 0, t);
    flush = 1'b1; wrr = 1'b1;
    tick();
    check("flush_valid", 256'(wr_valid), 256'(1));
    check("flush_mask", 256'(wr_mask), 256'(16'h0008));
    tick();
    check("flush_busy_fall", 256'(busy), 256'(0));
    flush = 1'b0;

    send(4, 10, 8, 0, 0, 0, 0, 0, t);
    send(4, 10, 16, 0, 0, 0, 1, 0, t);
    flush_all();
    check("overwrite_r5", 256'(lb_data[64 +: 5]), 256'(2));
    check("force_mask_bit", 256'(lb_data[79]), 256'(1));

    for (int i = 0; i < 600; i++) begin
      pv   = ($urandom_range(0, 3) != 0);
      px   = 10'($urandom_range(0, 47));
      py   = 9'($urandom_range(0, 2));
      pr   = 8'($urandom);
      pg   = 8'($urandom);
      pb   = 8'($urandom);
      stp  = 1'($urandom);
      fm   = ($urandom_range(0, 7) == 0);
      dith = 1'($urandom);
      wrr  = ($urandom_range(0, 2) != 0);
      tick();
    end
    for (int i = 0; i < 48; i++) send(i, 3, i * 5, i * 3, i, 0, 0, 1, t);
    flush_all();
    check("all_bursts_seen", 256'(exp_q.size()), 256'(0));

    wrr = 1'b0;
    send(0, 2, 10, 20, 30, 0, 0, 0, t);
    send(16, 2, 40, 50, 60, 0, 0, 0, t);
    check("prerst_busy", 256'(busy), 256'(1));
    check("prerst_ready", 256'(ready), 256'(0));
    rst = 1'b1;
    tick();
    check("midrst_valid", 256'(wr_valid), 256'(0));
    check("midrst_busy", 256'(busy), 256'(0));
    check("midrst_ready", 256'(ready), 256'(1));
    check("midrst_mask", 256'(wr_mask), 256'(0));
    rst = 1'b0;
    exp_q.delete();
    m_open = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
